// File: rtl/dot_product_unit_pkg.sv
// Shared definitions for the streaming dot-product unit.
// Holds the control FSM state type, the default operand/vector sizes, and
// the helper that sizes the element counter so it can hold VEC_LEN itself.
package dot_product_unit_pkg;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2
  } state_e;

  localparam int DEF_WIDTH_A = 8;
  localparam int DEF_WIDTH_B = 8;
  localparam int DEF_VEC_LEN = 16;

  // One bit wider than the index range so that a full vector's count
  // (VEC_LEN) is representable.
  function automatic int cnt_width(input int vec_len);
    return $clog2(vec_len) + 1;
  endfunction

endpackage

// File: rtl/dot_product_unit_array_multiplier.sv
// ArrayMultiplier: purely combinational unsigned multiplier.
// Ports:
//   a        in  WIDTH_A       multiplicand
//   b        in  WIDTH_B       multiplier
//   product  out OUTPUT_WIDTH  a * b, truncated/extended to OUTPUT_WIDTH
module ArrayMultiplier #(
  parameter int WIDTH_A      = 8,
  parameter int WIDTH_B      = 8,
  parameter int OUTPUT_WIDTH = WIDTH_A + WIDTH_B
) (
  input  logic [WIDTH_A-1:0]      a,
  input  logic [WIDTH_B-1:0]      b,
  output logic [OUTPUT_WIDTH-1:0] product
);

  always_comb begin
    product = OUTPUT_WIDTH'(a) * OUTPUT_WIDTH'(b);
  end

endmodule

// File: rtl/dot_product_unit.sv
// dot_product_unit: streaming unsigned dot-product engine.
// Operand pairs arrive one per cycle on a valid/ready handshake, pass through
// an operand register (S1), the ArrayMultiplier, a product register (S2) and
// a saturating accumulator. A vector ends on in_last or on its VEC_LEN-th
// element; its sum, element count and saturation flag are then held on the
// result port until the consumer takes them.
// Ports:
//   clk, rst_n             clock (rising edge), async active-low reset
//   in_valid/in_ready      operand handshake; in_a, in_b, in_last payload
//   out_valid/out_ready    result handshake; out_sum, out_count, out_sat payload
module dot_product_unit
  import dot_product_unit_pkg::*;
#(
  parameter int WIDTH_A   = DEF_WIDTH_A,
  parameter int WIDTH_B   = DEF_WIDTH_B,
  parameter int VEC_LEN   = DEF_VEC_LEN,
  parameter int ACC_WIDTH = WIDTH_A + WIDTH_B + $clog2(VEC_LEN),
  parameter int CNT_WIDTH = cnt_width(VEC_LEN)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH_A-1:0]   in_a,
  input  logic [WIDTH_B-1:0]   in_b,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_sum,
  output logic [CNT_WIDTH-1:0] out_count,
  output logic                 out_sat
);

  localparam int PROD_W = WIDTH_A + WIDTH_B;
  localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(VEC_LEN - 1);

  state_e state_q, state_d;

  logic in_fire;
  logic out_fire;
  logic in_last_eff;
  logic [CNT_WIDTH-1:0] in_cnt;

  logic               s1_valid;
  logic               s1_last;
  logic [WIDTH_A-1:0] s1_a;
  logic [WIDTH_B-1:0] s1_b;
  logic [PROD_W-1:0]  mult_p;

  logic              s2_valid;
  logic              s2_last;
  logic [PROD_W-1:0] s2_prod;

  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 sat_q, sat_d;
  logic [ACC_WIDTH:0]   sum_wide;

  // Gated by rst_n so the unit never advertises readiness while held in reset.
  assign in_ready  = rst_n & (state_q == ACCUM);
  assign out_valid = (state_q == HOLD);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  // A vector also closes on its VEC_LEN-th accepted element.
  assign in_last_eff = in_last | (in_cnt == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_cnt <= '0;
    end else if (in_fire) begin
      in_cnt <= in_last_eff ? '0 : in_cnt + CNT_WIDTH'(1);
    end
  end

  // S1: operand register in front of the multiplier.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
    end else begin
      s1_valid <= in_fire;
      if (in_fire) begin
        s1_last <= in_last_eff;
        s1_a    <= in_a;
        s1_b    <= in_b;
      end
    end
  end

  ArrayMultiplier #(
    .WIDTH_A      (WIDTH_A),
    .WIDTH_B      (WIDTH_B),
    .OUTPUT_WIDTH (PROD_W)
  ) u_mult (
    .a       (s1_a),
    .b       (s1_b),
    .product (mult_p)
  );

  // S2: product register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_last  <= 1'b0;
      s2_prod  <= '0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_last <= s1_last;
        s2_prod <= mult_p;
      end
    end
  end

  // Saturating accumulate. The sum is formed one bit wider so the carry out
  // of ACC_WIDTH marks overflow; once saturated the vector stays at all-ones.
  assign sum_wide = {1'b0, acc_q} + (ACC_WIDTH + 1)'(s2_prod);

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    sat_d = sat_q;
    if (s2_valid) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
      if (cnt_q == '0) begin
        acc_d = ACC_WIDTH'(s2_prod);
        sat_d = 1'b0;
      end else if (sat_q || sum_wide[ACC_WIDTH]) begin
        acc_d = '1;
        sat_d = 1'b1;
      end else begin
        acc_d = sum_wide[ACC_WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else if (out_fire) begin
      acc_q <= '0;
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else if (s2_valid) begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      sat_q <= sat_d;
    end
  end

  // Result register: captured from the accumulator's next value in the same
  // cycle the final product is consumed, then frozen until the next vector ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_sum   <= '0;
      out_count <= '0;
      out_sat   <= 1'b0;
    end else if (s2_valid && s2_last) begin
      out_sum   <= acc_d;
      out_count <= cnt_d;
      out_sat   <= sat_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACCUM;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ACCUM: if (in_fire && in_last_eff) state_d = DRAIN;
      DRAIN: if (s2_valid && s2_last)    state_d = HOLD;
      HOLD:  if (out_ready)              state_d = ACCUM;
      default:                           state_d = ACCUM;
    endcase
  end

endmodule

// File: doc/dot_product_unit.md
# dot_product_unit

- Streaming unsigned dot-product engine that sits directly downstream of ArrayMultiplier.
- Accepts one operand pair per cycle over a valid/ready handshake and registers the operands in front of the multiplier.
- Registers each product and accumulates the products of a vector of up to VEC_LEN elements.
- Presents the saturated sum and element count on a valid/ready result port.

## Interface
- WIDTH_A, 8, operand A width (unsigned)
- WIDTH_B, 8, operand B width (unsigned)
- VEC_LEN, 16, maximum elements per vector (>=2)
- ACC_WIDTH, WIDTH_A+WIDTH_B+$clog2(VEC_LEN), accumulator/result width (>= WIDTH_A+WIDTH_B)
- CNT_WIDTH, $clog2(VEC_LEN)+1, element-count width
- clk  in  1  sole clock, rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- in_valid  in  1  operand pair valid
- in_ready  out  1  unit accepts a pair this cycle
- in_a  in  WIDTH_A  operand A
- in_b  in  WIDTH_B  operand B
- in_last  in  1  pair is final element of vector
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_sum  out  ACC_WIDTH  dot product, saturated
- out_count  out  CNT_WIDTH  elements in vector (1..VEC_LEN)
- out_sat  out  1  saturation occurred in this vector

## Operation
- Input fire = in_valid & in_ready. Output fire = out_valid & out_ready.
- Pipeline:
  - S1 registers {a, b, last, valid}.
  - The multiplier is combinational on S1; S2 registers {product, last, valid}.
  - The accumulator stage consumes S2.
- End of vector:
  - A fire with in_last=1 ends the vector.
  - A fire that is the VEC_LEN-th element also ends the vector, with last forced to 1 internally.
  - In either case the next fire starts a new vector.
- Accumulate:
  - For the first element, acc = product.
  - For later elements, acc = acc + product, computed at ACC_WIDTH+1 bits.
  - If the sum exceeds 2^ACC_WIDTH-1, acc clamps to all-ones and the sticky sat flag sets.
  - Once saturated, acc stays all-ones for the rest of the vector.
- Count increments per element; its maximum value is VEC_LEN.
- FSM states:
  - ACCUM: in_ready=1.
    - Fire with last goes to DRAIN.
  - DRAIN: in_ready=0; the pipeline empties.
    - When the last element is accumulated, load out_sum/out_count/out_sat and go to HOLD.
  - HOLD: out_valid=1; outputs stable.
    - Output fire clears acc, count and sat, then goes to ACCUM.
- in_a, in_b and in_last are don't-care when in_valid=0; bubbles do not advance the count.
- Reset values: in_ready=0 while rst_n=0; out_valid=0; out_sum=0; out_count=0; out_sat=0; all pipeline valids=0; FSM=ACCUM.
- in_ready=1 from the first cycle after rst_n deasserts.
- Reset mid-vector or in HOLD discards partial and pending results. No output fire occurs for the discarded vector.

## Timing
- Vector-end latency, with the last input fire in cycle 0:
  - S1 is loaded at the end of cycle 0 and S2 at the end of cycle 1.
  - The result register is loaded at the end of cycle 2.
  - out_valid is high in cycle 3.
- in_ready is low from cycle 1 until the output-fire cycle inclusive. It is high again in the cycle after the output fire.
- Throughput:
  - One pair per cycle within a vector.
  - Per-vector overhead is 3 cycles plus the out_ready wait.
- Output outputs (out_sum, out_count, out_sat) must not change while out_valid=1 && out_ready=0.
- No combinational path from out_ready or in_valid to in_ready. in_ready is a function of the registered FSM only.

## Structure
- A shared package holds:
  - the FSM state enum (ACCUM, DRAIN, HOLD);
  - the default-width constants;
  - a function computing CNT_WIDTH.
- One sub-module instance: the existing ArrayMultiplier, between S1 and S2.
  - Parameters: WIDTH_A, WIDTH_B, OUTPUT_WIDTH=WIDTH_A+WIDTH_B.
- The saturating accumulator is inline logic, not a separate module.

## Test plan
- Reset then 4-element vector (a,b) = (1,2),(3,4),(5,6),(7,8 last) -> out_sum=100, out_count=4, out_sat=0; out_valid in cycle 3 after the last fire.
- 16 pairs (255,255) with no in_last, VEC_LEN=16 -> forced end; out_sum=1040400, out_count=16, in_ready=0 immediately after the 16th fire.
- ACC_WIDTH=16, 2 pairs (255,255) -> 65025+65025 overflows; out_sum=65535, out_sat=1. The next vector (2,3 last) -> out_sum=6, out_sat=0.
- Hold out_ready=0 for 10 cycles after out_valid -> out_sum/out_count stable and in_ready=0 throughout; in_ready=1 the cycle after the out_ready pulse.
- Random in_valid bubbles in a 5-element vector -> same result as without bubbles; out_count=5.
- rst_n low for 1 cycle after the 2nd element of a vector -> out_valid stays 0 and no result emitted. Next vector (9,9 last) -> out_sum=81, out_count=1.
